// File: rtl/wb_link_arbiter_pkg.sv
// Shared constants for the two-master link arbiter and its watchdog.
// Bus widths default to the board configuration values.
package wb_link_arbiter_pkg;

    localparam int WB_ADDR_W_DEF = 24;
    localparam int RW_DEF = 16;

    localparam int SEL_W = 2;

    // A disabled watchdog (timeout 0) still needs a 1-bit counter to stay legal.
    function automatic int cnt_width(input int timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/wb_link_arbiter_watchdog.sv
// Per-beat stall counter; o_expire fires on the stalled cycle that reaches TIMEOUT.
// TIMEOUT=0 disables it.
module wb_arb_watchdog
    import wb_link_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_active,
    input  logic i_stall,
    output logic o_expire
);
    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;

    // Any ack/err or a dropped strobe clears the count, so only one beat is timed.
    always_comb begin
        count_d  = '0;
        o_expire = 1'b0;
        if ((TIMEOUT != 0) && i_active && i_stall) begin
            if (count_q == LAST) begin
                o_expire = 1'b1;
                count_d  = count_q;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_link_arbiter.sv
// Round-robin Wishbone arbiter sharing the compressed off-chip link between the
// fetch master (m0) and the data master (m1); grant is held for a whole cycle.
module wb_link_arbiter
    import wb_link_arbiter_pkg::*;
#(
    parameter int ADDR_W  = WB_ADDR_W_DEF,
    parameter int DW      = RW_DEF,
    parameter int TIMEOUT = 255,
    parameter int GAP     = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              m0_cyc,
    input  logic              m0_stb,
    input  logic [ADDR_W-1:0] m0_adr,
    input  logic [DW-1:0]     m0_o_dat,
    input  logic              m0_we,
    input  logic [SEL_W-1:0]  m0_sel,
    input  logic              m0_8_burst,
    input  logic              m0_4_burst,
    output logic [DW-1:0]     m0_i_dat,
    output logic              m0_ack,
    output logic              m0_err,
    input  logic              m1_cyc,
    input  logic              m1_stb,
    input  logic [ADDR_W-1:0] m1_adr,
    input  logic [DW-1:0]     m1_o_dat,
    input  logic              m1_we,
    input  logic [SEL_W-1:0]  m1_sel,
    input  logic              m1_8_burst,
    input  logic              m1_4_burst,
    output logic [DW-1:0]     m1_i_dat,
    output logic              m1_ack,
    output logic              m1_err,
    output logic              s_cyc,
    output logic              s_stb,
    output logic [ADDR_W-1:0] s_adr,
    output logic [DW-1:0]     s_o_dat,
    output logic              s_we,
    output logic [SEL_W-1:0]  s_sel,
    output logic              s_8_burst,
    output logic              s_4_burst,
    input  logic [DW-1:0]     s_i_dat,
    input  logic              s_ack,
    input  logic              s_err
);
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_TMO, ST_REL} state_t;

    localparam int REL_CYCLES = (GAP == 0) ? 1 : GAP;
    localparam int GW = (REL_CYCLES > 1) ? $clog2(REL_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(REL_CYCLES - 1);

    state_t        state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_grant_q, last_grant_d;
    logic          tmo_err_q, tmo_err_d;
    logic [GW-1:0] gap_q, gap_d;

    logic req0, req1, g_cyc, busy, expire;

    assign req0  = m0_cyc & m0_stb;
    assign req1  = m1_cyc & m1_stb;
    assign g_cyc = grant_q ? m1_cyc : m0_cyc;
    assign busy  = (state_q == ST_BUSY);

    wb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_active (busy),
        .i_stall  (s_stb & ~s_ack & ~s_err),
        .o_expire (expire)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        gap_d        = gap_q;
        tmo_err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 | req1) begin
                    grant_d = (req0 & req1) ? ~last_grant_q : req1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Master abort takes priority over a simultaneous watchdog expiry.
                if (!g_cyc) begin
                    state_d = ST_REL;
                    gap_d   = '0;
                end else if (expire) begin
                    state_d   = ST_TMO;
                    tmo_err_d = 1'b1;
                end
            end
            ST_TMO: begin
                if (!g_cyc) begin
                    state_d = ST_REL;
                    gap_d   = '0;
                end
            end
            ST_REL: begin
                if (gap_q == GAP_LAST) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Everything outward is decoded from registered state, so reset silences it at once.
    always_comb begin
        s_cyc     = 1'b0;
        s_stb     = 1'b0;
        s_adr     = '0;
        s_o_dat   = '0;
        s_we      = 1'b0;
        s_sel     = '0;
        s_8_burst = 1'b0;
        s_4_burst = 1'b0;
        m0_ack    = 1'b0;
        m0_err    = 1'b0;
        m1_ack    = 1'b0;
        m1_err    = 1'b0;
        m0_i_dat  = '0;
        m1_i_dat  = '0;
        if (busy) begin
            s_cyc    = 1'b1;
            m0_i_dat = s_i_dat;
            m1_i_dat = s_i_dat;
            if (grant_q) begin
                s_stb     = m1_cyc & m1_stb;
                s_adr     = m1_adr;
                s_o_dat   = m1_o_dat;
                s_we      = m1_we;
                s_sel     = m1_sel;
                s_8_burst = m1_8_burst;
                s_4_burst = m1_4_burst;
                m1_ack    = s_ack;
                m1_err    = s_err;
            end else begin
                s_stb     = m0_cyc & m0_stb;
                s_adr     = m0_adr;
                s_o_dat   = m0_o_dat;
                s_we      = m0_we;
                s_sel     = m0_sel;
                s_8_burst = m0_8_burst;
                s_4_burst = m0_4_burst;
                m0_ack    = s_ack;
                m0_err    = s_err;
            end
        end else if (state_q == ST_TMO) begin
            if (grant_q) begin
                m1_err = tmo_err_q;
            end else begin
                m0_err = tmo_err_q;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            tmo_err_q    <= 1'b0;
            gap_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            tmo_err_q    <= tmo_err_d;
            gap_q        <= gap_d;
        end
    end

endmodule

// File: tb/tb_wb_link_arbiter.sv
// Directed and randomized bench for wb_link_arbiter; the bench plays both masters
// and the compressor, predicting the grant order from the round-robin rule.
module tb_wb_link_arbiter;
    localparam int AW  = 24;
    localparam int DW  = 16;
    localparam int TMO = 4;
    localparam int GAP = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          m0_cyc, m0_stb, m0_we, m0_8_burst, m0_4_burst, m0_ack, m0_err;
    logic [AW-1:0] m0_adr;
    logic [DW-1:0] m0_o_dat, m0_i_dat;
    logic [1:0]    m0_sel;
    logic          m1_cyc, m1_stb, m1_we, m1_8_burst, m1_4_burst, m1_ack, m1_err;
    logic [AW-1:0] m1_adr;
    logic [DW-1:0] m1_o_dat, m1_i_dat;
    logic [1:0]    m1_sel;
    logic          s_cyc, s_stb, s_we, s_8_burst, s_4_burst, s_ack, s_err;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_o_dat, s_i_dat;
    logic [1:0]    s_sel;

    int n_checks = 0;
    int n_errors = 0;
    int last_served = 1;

    wb_link_arbiter #(.ADDR_W(AW), .DW(DW), .TIMEOUT(TMO), .GAP(GAP)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_adr(m0_adr), .m0_o_dat(m0_o_dat),
        .m0_we(m0_we), .m0_sel(m0_sel), .m0_8_burst(m0_8_burst), .m0_4_burst(m0_4_burst),
        .m0_i_dat(m0_i_dat), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_adr(m1_adr), .m1_o_dat(m1_o_dat),
        .m1_we(m1_we), .m1_sel(m1_sel), .m1_8_burst(m1_8_burst), .m1_4_burst(m1_4_burst),
        .m1_i_dat(m1_i_dat), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_adr(s_adr), .s_o_dat(s_o_dat), .s_we(s_we),
        .s_sel(s_sel), .s_8_burst(s_8_burst), .s_4_burst(s_4_burst),
        .s_i_dat(s_i_dat), .s_ack(s_ack), .s_err(s_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ack_of(input int g);
        return (g == 0) ? m0_ack : m1_ack;
    endfunction

    function automatic logic err_of(input int g);
        return (g == 0) ? m0_err : m1_err;
    endfunction

    function automatic logic [DW-1:0] dat_of(input int g);
        return (g == 0) ? m0_i_dat : m1_i_dat;
    endfunction

    task automatic drive(input int g, input logic cyc, input logic stb, input logic [AW-1:0] adr,
                         input logic we, input logic [DW-1:0] dat, input logic [1:0] sel,
                         input logic b8, input logic b4);
        if (g == 0) begin
            m0_cyc = cyc; m0_stb = stb; m0_adr = adr; m0_we = we;
            m0_o_dat = dat; m0_sel = sel; m0_8_burst = b8; m0_4_burst = b4;
        end else begin
            m1_cyc = cyc; m1_stb = stb; m1_adr = adr; m1_we = we;
            m1_o_dat = dat; m1_sel = sel; m1_8_burst = b8; m1_4_burst = b4;
        end
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            #1;
            check(tag, 32'(s_cyc), 32'd0);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_s_cyc", 32'(s_cyc), 32'd0);
        check("rst_acks", 32'({m0_ack, m1_ack}), 32'd0);
        check("rst_errs", 32'({m0_err, m1_err}), 32'd0);
        drive(0, 1'b0, 1'b0, '0, 1'b0, '0, 2'b00, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, '0, 1'b0, '0, 2'b00, 1'b0, 1'b0);
        s_ack = 1'b0; s_err = 1'b0; s_i_dat = '0;
        @(negedge clk);
        rst_n = 1'b1;
        last_served = 1;
    endtask

    // Owner g runs a burst of 'beats' beats, each stalled a random 0..TMO-1 cycles
    // (an ack on the TIMEOUT-th stalled cycle must still win), then drops cyc.
    task automatic serve(input int g, input logic [AW-1:0] adr, input int beats, input logic we);
        logic [DW-1:0] rd, wd;
        logic [1:0]    sel;
        int            stall;
        sel = we ? 2'($urandom_range(1, 3)) : 2'b11;
        for (int b = 0; b < beats; b++) begin
            stall = $urandom_range(0, TMO - 1);
            rd = DW'($urandom);
            wd = DW'($urandom);
            for (int s = 0; s <= stall; s++) begin
                @(negedge clk);
                drive(g, 1'b1, 1'b1, adr + AW'(b), we, wd, sel, beats == 8, beats == 4);
                s_ack = (s == stall);
                s_i_dat = rd;
                #1;
                check("beat_s_cyc", 32'(s_cyc), 32'd1);
                check("beat_s_stb", 32'(s_stb), 32'd1);
                check("beat_s_adr", 32'(s_adr), 32'(adr + AW'(b)));
                check("beat_s_we", 32'(s_we), 32'(we));
                check("beat_s_sel", 32'(s_sel), 32'(sel));
                check("beat_burst", 32'({s_8_burst, s_4_burst}), 32'({beats == 8, beats == 4}));
                if (we) check("beat_s_o_dat", 32'(s_o_dat), 32'(wd));
                check("beat_ack_owner", 32'(ack_of(g)), 32'(s == stall));
                check("beat_ack_other", 32'(ack_of(1 - g)), 32'd0);
                check("beat_err", 32'({err_of(g), err_of(1 - g)}), 32'd0);
                if (s == stall && !we) check("beat_i_dat", 32'(dat_of(g)), 32'(rd));
            end
        end
        @(negedge clk);
        s_ack = 1'b0;
        drive(g, 1'b0, 1'b0, '0, 1'b0, '0, 2'b00, 1'b0, 1'b0);
        #1;
        check("drop_s_cyc_held", 32'(s_cyc), 32'd1);
        check("drop_ack", 32'(ack_of(g)), 32'd0);
    endtask

    // Reference rule: lone requester wins; a tie goes to whoever was not served last.
    // The loser waits GAP release cycles plus one arbitration cycle.
    task automatic round(input bit r0, input bit r1, input int nb0, input int nb1,
                         input bit we0, input bit we1);
        logic [AW-1:0] a0, a1;
        int            w;
        a0 = AW'($urandom) & 24'h7FFFF0;
        a1 = a0 | 24'h800000;
        @(negedge clk);
        if (r0) drive(0, 1'b1, 1'b1, a0, we0, '0, 2'b11, nb0 == 8, nb0 == 4);
        if (r1) drive(1, 1'b1, 1'b1, a1, we1, '0, 2'b11, nb1 == 8, nb1 == 4);
        #1;
        check("arb_idle_s_cyc", 32'(s_cyc), 32'd0);
        w = (r0 && r1) ? 1 - last_served : (r1 ? 1 : 0);
        serve(w, (w == 1) ? a1 : a0, (w == 1) ? nb1 : nb0, (w == 1) ? we1 : we0);
        last_served = w;
        if (r0 && r1) begin
            for (int k = 0; k < GAP + 1; k++) begin
                @(negedge clk);
                #1;
                check("wait_s_cyc", 32'(s_cyc), 32'd0);
                check("wait_ack", 32'(ack_of(1 - w)), 32'd0);
            end
            serve(1 - w, (w == 1) ? a0 : a1, (w == 1) ? nb0 : nb1, (w == 1) ? we0 : we1);
            last_served = 1 - w;
        end
        idle_cycles(GAP, "rel_s_cyc");
    endtask

    initial begin
        int nbs[3];
        bit r0, r1;
        nbs[0] = 1; nbs[1] = 4; nbs[2] = 8;
        drive(0, 1'b0, 1'b0, '0, 1'b0, '0, 2'b00, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, '0, 1'b0, '0, 2'b00, 1'b0, 1'b0);
        s_ack = 1'b0; s_err = 1'b0; s_i_dat = '0;
        apply_reset();

        // Single read from m0.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 24'h002010, 1'b0, '0, 2'b11, 1'b0, 1'b0);
        #1;
        check("t1_idle", 32'(s_cyc), 32'd0);
        @(negedge clk);
        #1;
        check("t1_s_cyc", 32'(s_cyc), 32'd1);
        check("t1_s_adr", 32'(s_adr), 32'h002010);
        s_ack = 1'b1; s_i_dat = 16'hBEEF;
        #1;
        check("t1_m0_ack", 32'(m0_ack), 32'd1);
        check("t1_m0_i_dat", 32'(m0_i_dat), 32'hBEEF);
        check("t1_m1_ack", 32'(m1_ack), 32'd0);
        @(negedge clk);
        s_ack = 1'b0;
        drive(0, 1'b0, 1'b0, '0, 1'b0, '0, 2'b00, 1'b0, 1'b0);
        #1;
        check("t1_drop", 32'(s_cyc), 32'd1);
        idle_cycles(GAP, "t1_rel");

        // Ties alternate starting with m0 after reset.
        apply_reset();
        round(1, 1, 1, 1, 0, 0);
        round(1, 1, 4, 1, 0, 1);

        // m1 8-beat write burst while m0 waits.
        round(1, 0, 1, 0, 0, 0);
        round(1, 1, 1, 8, 0, 1);

        // Watchdog expiry: err pulses once after TMO stalled cycles.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 24'h000300, 1'b0, '0, 2'b11, 1'b0, 1'b0);
        #1;
        check("t4_idle", 32'(s_cyc), 32'd0);
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            #1;
            check("t4_stall_s_cyc", 32'(s_cyc), 32'd1);
            check("t4_stall_err", 32'(m0_err), 32'd0);
        end
        @(negedge clk);
        #1;
        check("t4_tmo_s_cyc", 32'({s_cyc, s_stb}), 32'd0);
        check("t4_err_pulse", 32'(m0_err), 32'd1);
        check("t4_m1_err", 32'(m1_err), 32'd0);
        @(negedge clk);
        s_ack = 1'b1;
        #1;
        check("t4_err_once", 32'(m0_err), 32'd0);
        check("t4_late_ack", 32'(m0_ack), 32'd0);
        @(negedge clk);
        s_ack = 1'b0;
        drive(0, 1'b0, 1'b0, '0, 1'b0, '0, 2'b00, 1'b0, 1'b0);
        #1;
        check("t4_drop_err", 32'(m0_err), 32'd0);
        idle_cycles(GAP, "t4_rel");
        last_served = 0;

        // Ack on the TMO-th stalled cycle wins over the watchdog.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 24'h000400, 1'b0, '0, 2'b11, 1'b0, 1'b0);
        #1;
        check("t5_idle", 32'(s_cyc), 32'd0);
        for (int k = 0; k < TMO - 1; k++) begin
            @(negedge clk);
            #1;
            check("t5_stall_ack", 32'(m0_ack), 32'd0);
        end
        @(negedge clk);
        s_ack = 1'b1; s_i_dat = 16'h5A5A;
        #1;
        check("t5_ack", 32'(m0_ack), 32'd1);
        check("t5_no_err", 32'(m0_err), 32'd0);
        @(negedge clk);
        s_ack = 1'b0;
        drive(0, 1'b0, 1'b0, '0, 1'b0, '0, 2'b00, 1'b0, 1'b0);
        #1;
        check("t5_still_busy", 32'(s_cyc), 32'd1);
        check("t5_no_err_after", 32'(m0_err), 32'd0);
        idle_cycles(GAP, "t5_rel");
        last_served = 0;

        // Simultaneous ack and err are both forwarded to m1.
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 24'h000200, 1'b0, '0, 2'b11, 1'b0, 1'b0);
        #1;
        check("t7_idle", 32'(s_cyc), 32'd0);
        @(negedge clk);
        s_ack = 1'b1; s_err = 1'b1;
        #1;
        check("t7_m1_ack_err", 32'({m1_ack, m1_err}), 32'd3);
        check("t7_m0_ack_err", 32'({m0_ack, m0_err}), 32'd0);
        @(negedge clk);
        s_ack = 1'b0; s_err = 1'b0;
        drive(1, 1'b0, 1'b0, '0, 1'b0, '0, 2'b00, 1'b0, 1'b0);
        #1;
        check("t7_drop", 32'(s_cyc), 32'd1);
        idle_cycles(GAP, "t7_rel");
        last_served = 1;

        // Asynchronous reset in the middle of a 4-beat burst.
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 24'h000100, 1'b0, '0, 2'b11, 1'b0, 1'b1);
        #1;
        check("t6_idle", 32'(s_cyc), 32'd0);
        @(negedge clk);
        s_ack = 1'b1; s_i_dat = 16'h1234;
        #1;
        check("t6_beat0", 32'(m1_ack), 32'd1);
        check("t6_beat0_dat", 32'(m1_i_dat), 32'h1234);
        @(negedge clk);
        m1_adr = 24'h000101;
        #1;
        check("t6_beat1", 32'(m1_ack), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_s_cyc", 32'({s_cyc, s_stb}), 32'd0);
        check("t6_rst_ack", 32'({m0_ack, m1_ack}), 32'd0);
        check("t6_rst_err", 32'({m0_err, m1_err}), 32'd0);
        check("t6_rst_i_dat", 32'(m1_i_dat), 32'd0);
        s_ack = 1'b0;
        drive(1, 1'b0, 1'b0, '0, 1'b0, '0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        last_served = 1;
        round(1, 1, 1, 1, 0, 0);

        // Randomized traffic against the round-robin reference.
        for (int r = 0; r < 24; r++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            round(r0, r1, nbs[$urandom_range(0, 2)], nbs[$urandom_range(0, 2)],
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
